// File: rtl/a51_cipher_streamer_pkg.sv
// Shared types and constants for the A5/1 ciphertext-to-LCD streamer.
// Holds the FSM encoding, ASCII offsets and counter sizing helpers.
package a51_cipher_streamer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_XOR     = 3'd2,
    S_EMIT    = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_ZERO       = 8'h30;
  localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;

  localparam int DEFAULT_DATA_WIDTH = 128;
  localparam int DEFAULT_NIBBLES    = DEFAULT_DATA_WIDTH / 4;

  // Bits needed to hold any value in 0..max_val (never less than one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/a51_cipher_streamer_hextoascii.sv
// Converts one hex nibble to its uppercase ASCII character.
module a51_cipher_streamer_hextoascii
  import a51_cipher_streamer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_ZERO + {4'd0, nibble};
    if (nibble > 4'd9) ascii = ASCII_A_MINUS_10 + {4'd0, nibble};
  end

endmodule

// File: rtl/a51_cipher_streamer.sv
// Packs the serial A5/1 keystream, XORs it with the message and streams
// the ciphertext to the LCD as hex ASCII, most-significant nibble first.
module a51_cipher_streamer
  import a51_cipher_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ks_bit,
  input  logic                  ks_valid,
  input  logic                  ks_done,
  input  logic [DATA_WIDTH-1:0] plaintext,
  input  logic                  lcd_ready,
  output logic [7:0]            lcd_data,
  output logic                  lcd_enable,
  output logic [DATA_WIDTH-1:0] ciphertext,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int BIT_W   = cnt_width(DATA_WIDTH);
  localparam int NIB_W   = cnt_width(NIBBLES - 1);
  localparam int GAP_W   = cnt_width(GAP_CYCLES);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   sr;
  logic [BIT_W-1:0]        bit_cnt;
  logic [NIB_W-1:0]        nib_idx;
  logic [GAP_W-1:0]        gap_cnt;
  logic [3:0]              cur_nibble;
  logic [7:0]              cur_ascii;

  assign cur_nibble = ciphertext[(DATA_WIDTH - 1) - 4 * int'(nib_idx) -: 4];

  a51_cipher_streamer_hextoascii u_hex (
    .nibble (cur_nibble),
    .ascii  (cur_ascii)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      nib_idx    <= '0;
      gap_cnt    <= '0;
      lcd_data   <= 8'h00;
      lcd_enable <= 1'b0;
      ciphertext <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      lcd_enable <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sr       <= '0;
            bit_cnt  <= '0;
            nib_idx  <= '0;
            gap_cnt  <= '0;
            done     <= 1'b0;
            underrun <= 1'b0;
            busy     <= 1'b1;
            state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          // A bit arriving with ks_done is captured before the underrun test.
          if (ks_valid) begin
            sr      <= {sr[DATA_WIDTH-2:0], ks_bit};
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= S_XOR;
            end else if (ks_done) begin
              underrun <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end
          end else if (ks_done) begin
            underrun <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_XOR: begin
          ciphertext <= sr ^ plaintext;
          nib_idx    <= '0;
          state      <= S_EMIT;
        end
        S_EMIT: begin
          if (lcd_ready) begin
            lcd_data   <= cur_ascii;
            lcd_enable <= 1'b1;
            nib_idx    <= nib_idx + NIB_W'(1);
            if (nib_idx == LAST_NIB) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else if (GAP_CYCLES == 0) begin
              state <= S_EMIT;
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == LAST_GAP) state <= S_EMIT;
          else gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a51_cipher_streamer.sv
// Directed bench for a51_cipher_streamer: drivers push expected characters,
// a negedge monitor pops and compares every lcd_enable strobe.
module tb_a51_cipher_streamer;

  localparam int W   = 128;
  localparam int GAP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         ks_bit = 1'b0;
  logic         ks_valid = 1'b0;
  logic         ks_done = 1'b0;
  logic [W-1:0] plaintext = '0;
  logic         lcd_ready = 1'b0;
  logic [7:0]   lcd_data;
  logic         lcd_enable;
  logic [W-1:0] ciphertext;
  logic         busy;
  logic         done;
  logic         underrun;

  a51_cipher_streamer #(
    .DATA_WIDTH (W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .start      (start),
    .ks_bit     (ks_bit),
    .ks_valid   (ks_valid),
    .ks_done    (ks_done),
    .plaintext  (plaintext),
    .lcd_ready  (lcd_ready),
    .lcd_data   (lcd_data),
    .lcd_enable (lcd_enable),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] exp_c;
  int  n_cmp = 0;
  int  n_fail = 0;
  int  en_cnt = 0;
  int  first_en_cyc = 0;
  int  last_en_cyc = 0;
  bit  check_gap = 1'b1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not seen, expected within cycle budget", name);
  endtask

  // monitor
  always @(negedge clk) begin
    if (lcd_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL lcd_unexpected: got char %h, expected no strobe", lcd_data);
      end else begin
        exp_c = exp_q.pop_front();
        check($sformatf("lcd_data[%0d]", en_cnt), W'(lcd_data), W'(exp_c));
      end
      if (en_cnt > 0 && check_gap)
        check("enable_spacing", W'(cyc - last_en_cyc), W'(GAP + 1));
      if (en_cnt == 0) first_en_cyc = cyc;
      last_en_cyc = cyc;
      en_cnt++;
    end
  end

  // drivers
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_stream(input logic [W-1:0] ks, input int nbits, input int mid_start,
                             output int cap_cyc);
    for (int i = 0; i < nbits; i++) begin
      ks_valid = 1'b1;
      ks_bit   = ks[W-1-i];
      start    = (i == mid_start);
      @(posedge clk); #1;
    end
    ks_valid = 1'b0;
    ks_bit   = 1'b0;
    start    = 1'b0;
    cap_cyc  = cyc;
  endtask

  task automatic wait_enables(input int n, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (en_cnt >= n) begin ok = 1'b1; break; end
    end
    if (!ok) expire(name);
  endtask

  task automatic run_full(input logic [W-1:0] pt, input logic [W-1:0] ks,
                          input logic [W-1:0] exp_ct, input int mid_start, input bit stall);
    int cap;
    bit ok;
    plaintext = pt;
    lcd_ready = 1'b1;
    en_cnt    = 0;
    check_gap = !stall;
    pulse_start();
    check("busy_after_start", W'(busy), W'(1));
    send_stream(ks, W, mid_start, cap);
    if (stall) begin
      wait_enables(5, "stall_arm");
      lcd_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("stall_enable", W'(lcd_enable), W'(0));
        check("stall_data", W'(lcd_data), W'(8'h34));
      end
      lcd_ready = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) expire("done_timeout");
    @(negedge clk);
    check("ciphertext", ciphertext, exp_ct);
    check("done", W'(done), W'(1));
    check("underrun", W'(underrun), W'(0));
    check("busy_at_done", W'(busy), W'(0));
    check("enable_count", W'(en_cnt), W'(32));
    check("queue_drained", W'(exp_q.size()), W'(0));
    check("first_char_latency", W'(first_en_cyc - cap), W'(2));
    exp_q.delete();
  endtask

  task automatic push_rep(input logic [7:0] c);
    for (int i = 0; i < 32; i++) exp_q.push_back(c);
  endtask

  task automatic push_hex_seq();
    string s = "0123456789ABCDEF";
    for (int i = 0; i < 32; i++) exp_q.push_back(s[i % 16]);
  endtask

  localparam logic [W-1:0] PT_SEQ = 128'h0123456789ABCDEF0123456789ABCDEF;

  initial begin
    int cap;
    bit ok;

    repeat (3) @(negedge clk);
    check("rst_lcd_data", W'(lcd_data), W'(0));
    check("rst_lcd_enable", W'(lcd_enable), W'(0));
    check("rst_ciphertext", ciphertext, '0);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_underrun", W'(underrun), W'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // all-ones keystream over a zero message
    push_rep(8'h46);
    run_full('0, '1, '1, -1, 1'b0);

    // zero keystream passes the message through
    push_hex_seq();
    run_full(PT_SEQ, '0, PT_SEQ, -1, 1'b0);

    // alternating keystream against all-ones, with a start pulse ignored mid-collect
    push_rep(8'h35);
    run_full('1, {64{2'b10}}, {64{2'b01}}, 40, 1'b0);

    // keystream ends after 100 bits
    plaintext = '0;
    lcd_ready = 1'b1;
    en_cnt    = 0;
    pulse_start();
    send_stream('1, 100, -1, cap);
    ks_done = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (underrun) begin ok = 1'b1; break; end
    end
    if (!ok) expire("underrun_timeout");
    check("underrun_flag", W'(underrun), W'(1));
    check("underrun_busy", W'(busy), W'(0));
    check("underrun_done", W'(done), W'(0));
    ks_done = 1'b0;
    repeat (5) @(negedge clk);
    check("underrun_no_enables", W'(en_cnt), W'(0));
    push_rep(8'h46);
    run_full('0, '1, '1, -1, 1'b0);

    // LCD back-pressure at character 5
    push_hex_seq();
    run_full(PT_SEQ, '0, PT_SEQ, -1, 1'b1);

    // async reset in the middle of emission
    push_hex_seq();
    plaintext = PT_SEQ;
    lcd_ready = 1'b1;
    en_cnt    = 0;
    check_gap = 1'b1;
    pulse_start();
    send_stream('0, W, -1, cap);
    wait_enables(7, "reset_arm");
    #2 rst = 1'b1;
    #1;
    check("mid_rst_lcd_data", W'(lcd_data), W'(0));
    check("mid_rst_lcd_enable", W'(lcd_enable), W'(0));
    check("mid_rst_ciphertext", ciphertext, '0);
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_done", W'(done), W'(0));
    check("mid_rst_underrun", W'(underrun), W'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_hex_seq();
    run_full(PT_SEQ, '0, PT_SEQ, -1, 1'b0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/a51_cipher_streamer.md
Name: a51_cipher_streamer

Overview:
- Consumes the serial A5/1 keystream (one bit per cycle while the keygen's output stage is active) and packs it into a 128-bit word.
- XORs that word with the stored 128-bit message to produce the ciphertext.
- Streams the ciphertext to the LCD as uppercase hex ASCII characters, most-significant nibble first, under a ready/enable handshake.
- Sits directly downstream of a51_keygen and upstream of the LCD driver.

Parameters:
- DATA_WIDTH, 128, message/keystream width in bits; must be a multiple of 4.
- GAP_CYCLES, 2, idle cycles inserted after each LCD character before the next may issue; 0 is legal.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; arms the block.
- ks_bit  input  1  keystream bit (a51out).
- ks_valid  input  1  ks_bit valid this cycle (KeyStreamReady).
- ks_done  input  1  keystream depleted (KeyStreamDepleted), level.
- plaintext  input  DATA_WIDTH  message word, stable from start to done.
- lcd_ready  input  1  LCD can accept a character this cycle.
- lcd_data  output  8  ASCII character.
- lcd_enable  output  1  one-cycle strobe; lcd_data valid.
- ciphertext  output  DATA_WIDTH  registered XOR result.
- busy  output  1  high in any state other than IDLE/DONE.
- done  output  1  all characters emitted; held until next start or reset.
- underrun  output  1  keystream ended early; held until next start or reset.

Behaviour:
- Reset (async, any state): state=IDLE. lcd_data=8'h00, lcd_enable=0, ciphertext=0, busy=0, done=0, underrun=0. Bit and nibble counters=0. Shift register=0.
- States: IDLE, COLLECT, XOR, EMIT, GAP, DONE.
- IDLE: on start, clear shift register, counters, done and underrun, then go to COLLECT. Other inputs are ignored.
- COLLECT:
  - Each cycle with ks_valid=1: shift register <= {sr[DATA_WIDTH-2:0], ks_bit}, bit_cnt++. The first keystream bit ends at bit DATA_WIDTH-1.
  - When the DATA_WIDTH-th bit is captured, the next state is XOR. Later ks_valid bits are ignored.
  - ks_done=1 with bit_cnt<DATA_WIDTH and no valid bit that cycle: underrun=1, go to IDLE, no characters emitted.
  - If ks_valid and ks_done are both high, the bit is captured first. Underrun is judged on the post-capture count.
- XOR: ciphertext <= sr ^ plaintext (one cycle), nib_idx=0, go to EMIT.
- EMIT:
  - Character = hex-to-ASCII of ciphertext[DATA_WIDTH-1-4*nib_idx -: 4] ('0'-'9' = 8'h30-8'h39, 'A'-'F' = 8'h41-8'h46).
  - In a cycle with lcd_ready=1: lcd_data is registered, lcd_enable=1 the following cycle only, and nib_idx++.
  - If the last nibble was sent, go to DONE; otherwise go to GAP (or stay in EMIT when GAP_CYCLES=0).
  - lcd_ready=0: stall. lcd_enable=0, lcd_data holds the last value.
- GAP: count GAP_CYCLES cycles, then return to EMIT.
- DONE: done=1, busy=0. On start, re-arm exactly as from IDLE.
- start while busy=1 is ignored.
- Latency:
  - 128th valid bit captured at cycle N.
  - XOR state at N+1; ciphertext valid at N+2.
  - First lcd_enable at N+3 if lcd_ready=1.
  - With continuous ready, successive enables are 1+GAP_CYCLES cycles apart.
- Exactly DATA_WIDTH/4 lcd_enable pulses per successful run.

Decomposition:
- Shared package:
  - state enum (3-bit encoding);
  - ASCII_ZERO=8'h30, ASCII_A_MINUS_10=8'h37;
  - NIBBLES=DATA_WIDTH/4 and counter widths via clog2.
- One sub-module: the existing hextoascii converter, instantiated on the selected nibble. Nibble selection is an indexed part-select, not a separate mux module.

Test Plan:
- plaintext=0, 128 ks_valid cycles with ks_bit=1, lcd_ready=1 -> ciphertext=all ones; 32 enables each with lcd_data=8'h46 ('F'); then done=1, underrun=0.
- plaintext=128'h0123456789ABCDEF0123456789ABCDEF, ks_bit=0 -> lcd_data sequence "0123456789ABCDEF" twice (8'h30..8'h39, 8'h41..8'h46); enables spaced 3 cycles with GAP_CYCLES=2.
- Keystream 128'hAAAA... (alternating bits starting with 1), plaintext=128'hFFFF... -> ciphertext=128'h5555...; 32 chars 8'h35.
- ks_done asserted after 100 valid bits -> underrun=1, busy=0, zero lcd_enable pulses; next start with a full stream succeeds and clears underrun.
- lcd_ready held 0 for 10 cycles at character 5 -> no enable, lcd_data stable; emission resumes with character 6 when ready returns; total 32 enables.
- Async reset asserted mid-EMIT (after 7 characters) -> all outputs zero immediately; start and a full stream -> emission restarts from the most-significant nibble.
